// File: rtl/updown_modulo_counter_pkg.sv
// Shared types for the up/down modulo counter: boundary modes and control state.
package updown_counter_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_t;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

endpackage

// File: rtl/updown_modulo_counter_step_calc.sv
// Combinational step arithmetic: candidate next count and boundary-crossing detection.
module counter_step_calc #(
    parameter int WIDTH      = 8,
    parameter int STEP_WIDTH = 4
) (
    input  logic [WIDTH-1:0]      count,
    input  logic [STEP_WIDTH-1:0] step,
    input  logic                  up_and_down,
    input  logic [WIDTH-1:0]      limit_lo,
    input  logic [WIDTH-1:0]      limit_hi,
    output logic [WIDTH-1:0]      next_count_raw,
    output logic                  up_evt,
    output logic                  down_evt
);

    logic [WIDTH:0] step_ext;
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    // One guard bit: a carry or borrow is itself a crossing, never a silent wrap.
    assign step_ext = {{(WIDTH + 1 - STEP_WIDTH){1'b0}}, step};
    assign sum      = {1'b0, count} + step_ext;
    assign diff     = {1'b0, count} - step_ext;

    assign up_evt   = up_and_down && (sum > {1'b0, limit_hi});
    assign down_evt = !up_and_down && (diff[WIDTH] || (diff[WIDTH-1:0] < limit_lo));

    assign next_count_raw = up_and_down ? sum[WIDTH-1:0] : diff[WIDTH-1:0];

endmodule

// File: rtl/updown_modulo_counter.sv
// Bounded up/down counter with load, programmable step, wrap/saturate/one-shot
// boundary handling, terminal-count pulse and sticky overflow/underflow flags.
module updown_modulo_counter
    import updown_counter_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int STEP_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_value,
    input  logic                  up_and_down,
    input  logic [STEP_WIDTH-1:0] step,
    input  logic [WIDTH-1:0]      limit_lo,
    input  logic [WIDTH-1:0]      limit_hi,
    input  logic [1:0]            mode,
    input  logic                  clr_flags,
    output logic [WIDTH-1:0]      count,
    output logic                  tc,
    output logic                  ovf,
    output logic                  unf,
    output logic                  done,
    output logic                  cfg_err
);

    state_t           state;
    mode_t            mode_e;
    logic [WIDTH-1:0] next_count_raw;
    logic             up_evt;
    logic             down_evt;
    logic [WIDTH-1:0] bound_count;

    assign mode_e  = mode_t'(mode);
    assign cfg_err = (limit_lo > limit_hi);
    assign done    = (state == HALT);

    counter_step_calc #(
        .WIDTH      (WIDTH),
        .STEP_WIDTH (STEP_WIDTH)
    ) u_step_calc (
        .count          (count),
        .step           (step),
        .up_and_down    (up_and_down),
        .limit_lo       (limit_lo),
        .limit_hi       (limit_hi),
        .next_count_raw (next_count_raw),
        .up_evt         (up_evt),
        .down_evt       (down_evt)
    );

    // Where the count lands after a crossing; the reserved mode falls back to wrap.
    always_comb begin
        bound_count = '0;
        case (mode_e)
            MODE_SAT, MODE_ONESHOT: bound_count = up_evt ? limit_hi : limit_lo;
            default:                bound_count = up_evt ? limit_lo : limit_hi;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= load_value;
            tc    <= 1'b0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
            state <= RUN;
        end else begin
            tc <= 1'b0;
            if (clr_flags) begin
                ovf <= 1'b0;
                unf <= 1'b0;
            end
            if (load) begin
                count <= load_value;
                state <= RUN;
            end else if (!cfg_err && state == RUN && en && step != '0) begin
                if (up_evt || down_evt) begin
                    // Later assignment to ovf/unf overrides a same-cycle clear.
                    count <= bound_count;
                    tc    <= 1'b1;
                    if (up_evt) ovf <= 1'b1;
                    if (down_evt) unf <= 1'b1;
                    if (mode_e == MODE_ONESHOT) state <= HALT;
                end else begin
                    count <= next_count_raw;
                end
            end
        end
    end

endmodule

// File: tb/tb_updown_modulo_counter.sv
// Randomised and directed scoreboard bench for updown_modulo_counter.
module tb_updown_modulo_counter;

    localparam int W  = 8;
    localparam int SW = 4;

    logic          clk;
    logic          reset;
    logic          en;
    logic          load;
    logic [W-1:0]  load_value;
    logic          up_and_down;
    logic [SW-1:0] step;
    logic [W-1:0]  limit_lo;
    logic [W-1:0]  limit_hi;
    logic [1:0]    mode;
    logic          clr_flags;
    logic [W-1:0]  count;
    logic          tc;
    logic          ovf;
    logic          unf;
    logic          done;
    logic          cfg_err;

    typedef struct {
        int count;
        bit tc;
        bit ovf;
        bit unf;
        bit done;
        bit cfg_err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference state
    int   m_count = 0;
    bit   m_tc    = 0;
    bit   m_ovf   = 0;
    bit   m_unf   = 0;
    bit   m_halt  = 0;

    updown_modulo_counter #(.WIDTH(W), .STEP_WIDTH(SW)) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .load        (load),
        .load_value  (load_value),
        .up_and_down (up_and_down),
        .step        (step),
        .limit_lo    (limit_lo),
        .limit_hi    (limit_hi),
        .mode        (mode),
        .clr_flags   (clr_flags),
        .count       (count),
        .tc          (tc),
        .ovf         (ovf),
        .unf         (unf),
        .done        (done),
        .cfg_err     (cfg_err)
    );

    // Clock and reset-time defaults
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Reference model: the count is a plain integer, crossings are judged on the
    // unbounded result of count +/- step against the inclusive window.
    task automatic model_step();
        int lo, hi, t;
        bit evt;
        lo = int'(limit_lo);
        hi = int'(limit_hi);
        if (reset) begin
            m_count = int'(load_value);
            m_tc = 0; m_ovf = 0; m_unf = 0; m_halt = 0;
            return;
        end
        m_tc = 0;
        if (clr_flags) begin
            m_ovf = 0;
            m_unf = 0;
        end
        if (load) begin
            m_count = int'(load_value);
            m_halt = 0;
        end else if (lo > hi || m_halt || !en || step == 0) begin
            // hold
        end else begin
            t   = up_and_down ? m_count + int'(step) : m_count - int'(step);
            evt = up_and_down ? (t > hi) : (t < lo);
            if (!evt) begin
                m_count = t;
            end else begin
                m_tc = 1;
                if (up_and_down) m_ovf = 1; else m_unf = 1;
                if (mode == 2'd1 || mode == 2'd2)
                    m_count = up_and_down ? hi : lo;
                else
                    m_count = up_and_down ? lo : hi;
                if (mode == 2'd2) m_halt = 1;
            end
        end
    endtask

    // Driver: inputs are already set; update model, queue expectation, advance.
    task automatic cycle();
        exp_t e;
        model_step();
        e.count   = m_count;
        e.tc      = m_tc;
        e.ovf     = m_ovf;
        e.unf     = m_unf;
        e.done    = m_halt;
        e.cfg_err = (limit_lo > limit_hi);
        exp_q.push_back(e);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_load(input int v);
        load = 1'b1;
        load_value = W'(v);
        cycle();
        load = 1'b0;
    endtask

    // Monitor: the counter presents a new result after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("count",   int'(count),   e.count);
                check("tc",      int'(tc),      int'(e.tc));
                check("ovf",     int'(ovf),     int'(e.ovf));
                check("unf",     int'(unf),     int'(e.unf));
                check("done",    int'(done),    int'(e.done));
                check("cfg_err", int'(cfg_err), int'(e.cfg_err));
            end
        end
    end

    initial begin
        reset = 1'b1; en = 1'b0; load = 1'b0; load_value = 8'h05;
        up_and_down = 1'b1; step = 4'd1; limit_lo = 8'd0; limit_hi = 8'd255;
        mode = 2'd0; clr_flags = 1'b0;

        // Reset, count a little, reset again mid-count
        cycle();
        reset = 1'b0; en = 1'b1;
        repeat (3) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0; en = 1'b0;

        // Wrap up 2..9 by 3: 5, 8, 2 (crossing); then 6 -> 9 exactly
        limit_lo = 8'd2; limit_hi = 8'd9; step = 4'd3; mode = 2'd0; up_and_down = 1'b1;
        do_load(2);
        en = 1'b1;
        repeat (3) cycle();
        en = 1'b0;
        do_load(6);
        en = 1'b1;
        cycle();
        en = 1'b0;

        // Saturate down 10..200 by 7 from 20; hold at floor with repeated tc
        limit_lo = 8'd10; limit_hi = 8'd200; step = 4'd7; mode = 2'd1; up_and_down = 1'b0;
        clr_flags = 1'b1;
        do_load(20);
        clr_flags = 1'b0;
        en = 1'b1;
        repeat (4) cycle();
        en = 1'b0; clr_flags = 1'b1;
        cycle();
        clr_flags = 1'b0;

        // One-shot up 0..255 by 15 from 250, then reload and resume
        limit_lo = 8'd0; limit_hi = 8'd255; step = 4'd15; mode = 2'd2; up_and_down = 1'b1;
        do_load(250);
        en = 1'b1;
        repeat (3) cycle();
        do_load(0);
        repeat (2) cycle();

        // Inverted limits freeze the count; load still wins; step 0 holds
        limit_lo = 8'd50; limit_hi = 8'd40; mode = 2'd0;
        repeat (2) cycle();
        do_load(77);
        cycle();
        limit_lo = 8'd0; limit_hi = 8'd255; step = 4'd0;
        repeat (2) cycle();

        // Down by 4 from 3 crosses the floor and wraps to 255
        en = 1'b0; clr_flags = 1'b1;
        do_load(3);
        clr_flags = 1'b0;
        step = 4'd4; up_and_down = 1'b0; mode = 2'd0; en = 1'b1;
        cycle();
        en = 1'b0; reset = 1'b1;
        cycle();
        reset = 1'b0;

        // Random traffic, biased toward narrow windows so crossings are frequent
        for (int i = 0; i < 600; i++) begin
            int a, b, wdt;
            reset       = ($urandom_range(0, 49) == 0);
            load        = ($urandom_range(0, 9) == 0);
            load_value  = W'($urandom_range(0, 255));
            clr_flags   = ($urandom_range(0, 7) == 0);
            en          = ($urandom_range(0, 3) != 0);
            step        = SW'($urandom_range(0, 15));
            up_and_down = $urandom_range(0, 1) == 1;
            mode        = 2'($urandom_range(0, 3));
            if (i % 20 == 0) begin
                a = $urandom_range(0, 255);
                wdt = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 30) : $urandom_range(0, 255);
                b = (a + wdt > 255) ? 255 : a + wdt;
                if ($urandom_range(0, 7) == 0) begin
                    limit_lo = W'(b); limit_hi = W'(a);
                end else begin
                    limit_lo = W'(a); limit_hi = W'(b);
                end
            end
            cycle();
        end
        reset = 1'b0; load = 1'b0; en = 1'b0; clr_flags = 1'b0;

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/updown_modulo_counter.md
Name: updown_modulo_counter

Overview:
- Parametrised up/down counter with synchronous load, programmable step, and programmable lower/upper limits.
- Three boundary modes: wrap, saturate, one-shot.
- Provides a terminal-count pulse and sticky overflow/underflow flags for timers, address generators and rate dividers.
- Next-generation general counter for the codebase; drop-in wherever a bounded, direction-controlled count is needed.

Parameters:
- WIDTH, 8, count/limit/load width in bits (>= 2)
- STEP_WIDTH, 4, width of the step input (1 <= STEP_WIDTH <= WIDTH)

Ports:
- clk  input  1  single clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- en  input  1  count enable; low holds count
- load  input  1  synchronous load of load_value
- load_value  input  WIDTH  value loaded on load or reset
- up_and_down  input  1  1 = count up, 0 = count down
- step  input  STEP_WIDTH  increment magnitude; 0 = hold, no events
- limit_lo  input  WIDTH  inclusive lower bound
- limit_hi  input  WIDTH  inclusive upper bound
- mode  input  2  boundary mode (see package)
- clr_flags  input  1  clears the sticky ovf/unf flags
- count  output  WIDTH  current count, registered
- tc  output  1  one-cycle terminal-count pulse, registered
- ovf  output  1  sticky: an up-boundary event occurred
- unf  output  1  sticky: a down-boundary event occurred
- done  output  1  high in HALT state (one-shot finished)
- cfg_err  output  1  combinational: limit_lo > limit_hi

Behaviour:
- Reset (synchronous, active-high) sets: count = load_value sampled that edge, tc = 0, ovf = 0, unf = 0, state = RUN, done = 0.
- Priority per edge: reset > load > cfg_err > en-step.
- load sets count = load_value, state = RUN, tc = 0; flags are untouched. Values outside the limits are loaded as-is.
- cfg_err = 1: count holds and tc = 0, regardless of en.
- Step arithmetic is done in WIDTH+1 bits so there is no silent wrap.
  - Up event: count + step > limit_hi.
  - Down event: count < step, or count - step < limit_lo.
- No event: count <= count ± step, and tc = 0.
- On an event, tc = 1 for exactly one cycle; ovf (up) or unf (down) is set.
  - MODE_WRAP: up → limit_lo; down → limit_hi.
  - MODE_SAT: up → limit_hi; down → limit_lo. tc pulses on every enabled cycle that attempts to exceed the bound.
  - MODE_ONESHOT: go to the bound as in SAT, then state = HALT.
  - Mode 2'b11 (reserved) behaves as MODE_WRAP.
- HALT: count holds, done = 1, en is ignored. Leave HALT only by load or reset.
- Reaching a limit exactly is not an event. The event fires on the step that would cross it.
- en = 0 or step = 0: count holds and tc = 0.
- clr_flags clears ovf/unf. If an event occurs in the same cycle, set wins.
- Changes to mode, limits, up_and_down or step take effect on the next enabled edge. No pipelining; latency from input to count is 1 cycle.

Decomposition:
- Package updown_counter_pkg:
  - mode_t enum: MODE_WRAP = 2'b00, MODE_SAT = 2'b01, MODE_ONESHOT = 2'b10, MODE_RSVD = 2'b11
  - state_t enum: RUN, HALT
- Sub-module counter_step_calc (combinational). Inputs: count, step, direction, limits. Outputs: next_count_raw, up_evt, down_evt.
- The top level holds the FSM, registers and flags.

Test Plan:
- Reset with load_value = 8'h05 → count = 5, tc/ovf/unf/done = 0 after one edge; reset asserted mid-count also returns to 5.
- WRAP, up, limits 2..9, step = 3, start 2 → count sequence 5, 8, then 2 with tc = 1 for one cycle and ovf = 1; exactly reaching 9 from 6 gives no tc.
- SAT, down, limits 10..200, step = 7, start 20 → count 13, then 10 with tc = 1; en held high → count stays 10 with tc pulsing each cycle; unf = 1, cleared by clr_flags.
- ONESHOT, up, limits 0..255, step = 15, start 250 → count = 255, tc = 1, done = 1; further en → count holds; load 8'h00 → done = 0 and counting resumes.
- limit_lo = 50, limit_hi = 40 → cfg_err = 1 and count holds under en; simultaneous load + en → load value wins; step = 0 → hold with tc = 0.
- Down step with count = 3, step = 4, limits 0..255 → underflow is detected (no wrap to 255 - 1); WRAP gives count = 255, tc = 1, unf = 1.
